gen_job_sched: RTL and testbench

- Job scheduler in front of a stream data generator that uses an ap_start/ap_ready/ap_done handshake.
- Queues transfer-length descriptors in a small FIFO and launches the generator once per descriptor.
- Holds the generator's size input stable for the whole job, monitors the output stream, and reports completion and protocol errors.
- Sits between the control/register side and the generator; issues no stream data itself.

---
 rtl/gen_job_sched.sv | 164 ++++++++++++++++
 tb/tb_gen_job_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_job_sched.sv
// Descriptor-queued launcher for an ap_start/ap_ready/ap_done stream generator.
// Define GEN_JOB_SCHED_PERF_EN to add the stall_cnt performance output.
module gen_job_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      job_size,
  input  logic             job_valid,
  output logic             job_ready,
  output logic [31:0]      gen_size,
  output logic             gen_start,
  input  logic             gen_ready,
  input  logic             gen_done,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic [CNT_W-1:0] skipped,
  output logic [1:0]       err,
  input  logic             err_clr,
`ifdef GEN_JOB_SCHED_PERF_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]      gen_size_q, gen_size_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] jobs_q, jobs_d, skip_q, skip_d;
  logic [1:0]       err_q, err_d, err_set;
  logic             irq_q, irq_d;
  logic             fifo_empty, fifo_full, push, pop, done_evt;
  logic             beat, tlast_beat;
  logic [31:0]      head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_FULL);
  assign push       = job_valid && !fifo_full;
  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign beat       = mon_tvalid && mon_tready;
  assign tlast_beat = beat && mon_tlast;

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= job_size;
  end

`ifdef GEN_JOB_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
`endif

  always_comb begin
    state_d    = state_q;
    gen_size_d = gen_size_q;
    beat_cnt_d = beat_cnt_q;
    jobs_d     = jobs_q;
    skip_d     = skip_q;
    err_set    = 2'b00;
    pop        = 1'b0;
    done_evt   = 1'b0;
`ifdef GEN_JOB_SCHED_PERF_EN
    stall_d    = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          // Zero-size jobs never produce ap_done, so they are dropped here.
          if (head == 32'd0) begin
            pop    = 1'b1;
            skip_d = skip_q + CNT_ONE;
          end else begin
            gen_size_d = head;
            beat_cnt_d = 32'd0;
            state_d    = LAUNCH;
`ifdef GEN_JOB_SCHED_PERF_EN
            stall_d    = 32'd0;
`endif
          end
        end
      end
      LAUNCH: begin
        if (gen_ready) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat) beat_cnt_d = beat_cnt_q + 32'd1;
`ifdef GEN_JOB_SCHED_PERF_EN
        if (mon_tvalid && !mon_tready) stall_d = stall_q + 32'd1;
`endif
        if (gen_done) begin
          // The done cycle carries the final beat, hence the +1.
          if (beat_cnt_q + 32'd1 != gen_size_q) err_set[0] = 1'b1;
          if (!tlast_beat) err_set[1] = 1'b1;
          jobs_d   = jobs_q + CNT_ONE;
          done_evt = 1'b1;
          state_d  = IDLE;
        end else if (tlast_beat) begin
          err_set[1] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    irq_d    = done_evt && (wr_ptr_d == rd_ptr_d);
    err_d    = (err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      gen_size_q <= '0;
      beat_cnt_q <= '0;
      jobs_q     <= '0;
      skip_q     <= '0;
      err_q      <= '0;
      irq_q      <= 1'b0;
`ifdef GEN_JOB_SCHED_PERF_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      gen_size_q <= gen_size_d;
      beat_cnt_q <= beat_cnt_d;
      jobs_q     <= jobs_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
`ifdef GEN_JOB_SCHED_PERF_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign job_ready = !fifo_full;
  assign gen_size  = gen_size_q;
  assign gen_start = (state_q == LAUNCH);
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign jobs_done = jobs_q;
  assign skipped   = skip_q;
  assign err       = err_q;
  assign irq       = irq_q;
`ifdef GEN_JOB_SCHED_PERF_EN
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gen_job_sched.sv
// Directed bench for gen_job_sched with a small ap_ctrl stream generator model.
module tb_gen_job_sched;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] job_size = '0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] gen_size;
  logic        gen_start, gen_ready, gen_done;
  logic        mon_tvalid, mon_tlast;
  logic        mon_tready = 1'b0;
  logic        busy;
  logic [15:0] jobs_done, skipped;
  logic [1:0]  err;
  logic        err_clr = 1'b0;
  logic        irq;
`ifdef GEN_JOB_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  gen_job_sched #(.DEPTH(4), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .job_size(job_size), .job_valid(job_valid), .job_ready(job_ready),
    .gen_size(gen_size), .gen_start(gen_start), .gen_ready(gen_ready), .gen_done(gen_done),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy), .jobs_done(jobs_done), .skipped(skipped), .err(err), .err_clr(err_clr),
`ifdef GEN_JOB_SCHED_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .irq(irq)
  );

  // Generator model: override forces the beat count, tlast_at moves tlast.
  logic        m_busy;
  logic [31:0] m_left, m_idx;
  int          m_override = 0;
  int          m_tlast_at = 0;
  logic        m_hold = 1'b0;

  assign gen_ready  = gen_start && !m_busy && !m_hold;
  assign mon_tvalid = m_busy;
  assign mon_tlast  = m_busy && ((m_tlast_at != 0) ? (m_idx == 32'(m_tlast_at)) : (m_left == 32'd1));
  assign gen_done   = m_busy && (m_left == 32'd1) && mon_tready;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_busy <= 1'b0;
      m_left <= '0;
      m_idx  <= '0;
    end else if (gen_start && gen_ready) begin
      m_busy <= 1'b1;
      m_left <= (m_override != 0) ? 32'(m_override) : gen_size;
      m_idx  <= 32'd1;
    end else if (m_busy && mon_tready) begin
      if (m_left == 32'd1) m_busy <= 1'b0;
      m_left <= m_left - 32'd1;
      m_idx  <= m_idx + 32'd1;
    end
  end

  // Activity monitor
  logic        mon_clr = 1'b0;
  int          start_cyc, launches, beats, irqs;
  logic [31:0] launch_log [8];

  always @(posedge ap_clk) begin
    if (mon_clr) begin
      start_cyc <= 0; launches <= 0; beats <= 0; irqs <= 0;
    end else begin
      if (gen_start) start_cyc <= start_cyc + 1;
      if (gen_start && gen_ready) begin
        if (launches < 8) launch_log[launches] <= gen_size;
        launches <= launches + 1;
      end
      if (mon_tvalid && mon_tready) beats <= beats + 1;
      if (irq) irqs <= irqs + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge ap_clk);
    mon_clr = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push(input logic [31:0] s);
    bit acc = 1'b0;
    job_valid = 1'b1;
    job_size  = s;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = job_ready;
      @(negedge ap_clk);
    end
    job_valid = 1'b0;
    check($sformatf("push_%0d_accepted", s), 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy) done = 1'b1;
      else @(negedge ap_clk);
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_job_ready", 32'(job_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gen_start", 32'(gen_start), 32'd0);
    check("rst_gen_size", gen_size, 32'd0);
    check("rst_counts", {jobs_done, skipped}, 32'd0);
    check("rst_err_irq", {29'd0, err, irq}, 32'd0);

    // Single job of 4 beats
    mon_tready = 1'b1;
    clear_mon();
    push(32'd4);
    check("t1_start_n1", 32'(gen_start), 32'd0);
    @(negedge ap_clk);
    check("t1_start_n2", 32'(gen_start), 32'd1);
    check("t1_gen_size", gen_size, 32'd4);
    wait_idle("t1");
    check("t1_irq_high", 32'(irq), 32'd1);
    check("t1_jobs_done", 32'(jobs_done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_start_cycles", 32'(start_cyc), 32'd1);
    check("t1_beats", 32'(beats), 32'd4);
    @(negedge ap_clk);
    check("t1_irq_low", 32'(irq), 32'd0);
    check("t1_irq_count", 32'(irqs), 32'd1);

    // 3, 0, 2 back to back: zero-size skipped
    clear_mon();
    push(32'd3);
    push(32'd0);
    push(32'd2);
    wait_idle("t2");
    @(negedge ap_clk);
    check("t2_skipped", 32'(skipped), 32'd1);
    check("t2_launches", 32'(launches), 32'd2);
    check("t2_launch0", launch_log[0], 32'd3);
    check("t2_launch1", launch_log[1], 32'd2);
    check("t2_jobs_done", 32'(jobs_done), 32'd3);
    check("t2_irq_count", 32'(irqs), 32'd1);
    check("t2_beats", 32'(beats), 32'd5);

    // Fill the FIFO while launch is held off
    clear_mon();
    mon_tready = 1'b0;
    m_hold = 1'b1;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    push(32'd1);
    check("t3_full_ready", 32'(job_ready), 32'd0);
    repeat (3) @(negedge ap_clk);
    check("t3_full_held", 32'(job_ready), 32'd0);
    m_hold = 1'b0;
    check("t3_full_at_pop", 32'(job_ready), 32'd0);
    @(negedge ap_clk);
    check("t3_ready_after_pop", 32'(job_ready), 32'd1);
    push(32'd2);
    repeat (2) @(negedge ap_clk);
    mon_tready = 1'b1;
    wait_idle("t3");
    @(negedge ap_clk);
    check("t3_launches", 32'(launches), 32'd5);
    check("t3_beats", 32'(beats), 32'd9);
    check("t3_jobs_done", 32'(jobs_done), 32'd8);
    check("t3_irq_count", 32'(irqs), 32'd1);
`ifdef GEN_JOB_SCHED_PERF_EN
    check("t3_stall_cnt", stall_cnt, 32'd0);
`endif

    // Short job: done after 6 of 8 beats
    m_override = 6;
    push(32'd8);
    wait_idle("t4");
    m_override = 0;
    check("t4_err_count", 32'(err), 32'd1);
    check("t4_jobs_done", 32'(jobs_done), 32'd9);
    @(negedge ap_clk);
    check("t4_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge ap_clk);
    err_clr = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    push(32'd2);
    wait_idle("t4b");
    check("t4b_err", 32'(err), 32'd0);
    check("t4b_jobs_done", 32'(jobs_done), 32'd10);

    // Early tlast on beat 2 of 4
    m_tlast_at = 2;
    push(32'd4);
    wait_idle("t5");
    m_tlast_at = 0;
    check("t5_err_tlast", 32'(err), 32'd2);
    check("t5_jobs_done", 32'(jobs_done), 32'd11);
    err_clr = 1'b1;
    @(negedge ap_clk);
    err_clr = 1'b0;

    // Reset during RUN with two descriptors queued
    mon_tready = 1'b0;
    push(32'd3);
    push(32'd2);
    push(32'd2);
    repeat (2) @(negedge ap_clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    ap_rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_counts", {jobs_done, skipped}, 32'd0);
    check("t6_rst_gen", {gen_size[30:0], gen_start}, 32'd0);
    check("t6_rst_ready", 32'(job_ready), 32'd1);
    check("t6_rst_err_irq", {29'd0, err, irq}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    mon_tready = 1'b1;
    clear_mon();
    repeat (8) @(negedge ap_clk);
    check("t6_no_start", 32'(start_cyc), 32'd0);
    check("t6_busy_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
